// File: rtl/mse_frame_packer.sv
// mse_frame_packer: captures NUM_RES MSE words and serialises them as a paced byte frame
// (header, payload, XOR checksum). Define MSE_FRAME_SEQ_EN to add a sequence byte after the header.
module mse_frame_packer #(
  parameter int         NUM_RES    = 2,
  parameter int         DATA_W     = 64,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         GAP_CYCLES = 8680
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_RES-1:0][DATA_W-1:0] mse_data,
  input  logic                           mse_valid,
  output logic                           com_txvalid,
  output logic [7:0]                     com_txdata,
  output logic                           busy,
  output logic                           overrun,
  output logic [7:0]                     frame_cnt
);
  localparam int TOT_W = NUM_RES * DATA_W;
  localparam int NB    = TOT_W / 8;
  localparam int IW    = $clog2(NB + 1);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef MSE_FRAME_SEQ_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
`endif

  state_t           state, state_nxt;
  logic [TOT_W-1:0] shadow;
  logic [7:0]       csum;
  logic [IW-1:0]    left;
  logic [GW-1:0]    gap;
  logic [7:0]       top_byte;
  logic [7:0]       tx_byte;
  logic             emit, accept, pay_emit, done;
`ifdef MSE_FRAME_SEQ_EN
  logic             seq_emit;
`endif

  // Word 0 lands in the top bits so the shadow can be shifted out MSB byte first.
  function automatic logic [TOT_W-1:0] flatten(input logic [NUM_RES-1:0][DATA_W-1:0] words);
    logic [TOT_W-1:0] flat;
    flat = '0;
    for (int w = 0; w < NUM_RES; w++) flat[(NUM_RES-1-w)*DATA_W +: DATA_W] = words[w];
    return flat;
  endfunction

  assign top_byte = shadow[TOT_W-1 -: 8];
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Each state emits its byte on entry; the transition out waits for the gap to run down.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    tx_byte   = '0;
    pay_emit  = 1'b0;
    done      = 1'b0;
`ifdef MSE_FRAME_SEQ_EN
    seq_emit  = 1'b0;
`endif
    accept    = (state == S_IDLE) && mse_valid;
    case (state)
      S_IDLE: if (accept) begin
        state_nxt = S_HDR;
        emit      = 1'b1;
        tx_byte   = HEADER;
      end
      S_HDR: if (gap == '0) begin
        emit = 1'b1;
`ifdef MSE_FRAME_SEQ_EN
        state_nxt = S_SEQ;
        tx_byte   = frame_cnt;
        seq_emit  = 1'b1;
`else
        state_nxt = S_DATA;
        tx_byte   = top_byte;
        pay_emit  = 1'b1;
`endif
      end
`ifdef MSE_FRAME_SEQ_EN
      S_SEQ: if (gap == '0) begin
        state_nxt = S_DATA;
        emit      = 1'b1;
        tx_byte   = top_byte;
        pay_emit  = 1'b1;
      end
`endif
      S_DATA: if (gap == '0) begin
        emit = 1'b1;
        if (left == '0) begin
          state_nxt = S_CSUM;
          tx_byte   = csum;
        end else begin
          tx_byte  = top_byte;
          pay_emit = 1'b1;
        end
      end
      S_CSUM: if (gap == '0) begin
        state_nxt = S_IDLE;
        done      = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      com_txvalid <= 1'b0;
      com_txdata  <= '0;
      gap         <= '0;
      shadow      <= '0;
      csum        <= '0;
      left        <= '0;
      overrun     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      com_txvalid <= emit;
      if (emit) begin
        com_txdata <= tx_byte;
        gap        <= GW'(GAP_CYCLES - 1);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
      if (accept) begin
        shadow <= flatten(mse_data);
        csum   <= '0;
        left   <= IW'(NB);
      end else if (pay_emit) begin
        shadow <= shadow << 8;
        csum   <= csum ^ top_byte;
        left   <= left - IW'(1);
      end
`ifdef MSE_FRAME_SEQ_EN
      else if (seq_emit) begin
        csum <= csum ^ frame_cnt;
      end
`endif
      if (done) frame_cnt <= frame_cnt + 8'd1;
      if (mse_valid && busy) overrun <= 1'b1;
    end
  end
endmodule

// File: doc/mse_frame_packer.md
Name: mse_frame_packer

Overview:
- Sits directly downstream of the MSE data collectors and directly upstream of the UART transmitter.
- Captures the MSE results of all DUT channels on a valid pulse and serialises them into one framed byte stream.
- Frame layout: header, payload, checksum.
- Paces bytes with a programmable gap so the UART transmitter, which has no ready signal, never receives a byte while still shifting the previous one.

Parameters:
- NUM_RES, 2, number of MSE result words per frame.
- DATA_W, 64, width of each MSE result in bits; must be a multiple of 8.
- HEADER, 8'hA5, frame start byte.
- GAP_CYCLES, 8680, clock cycles from one byte strobe to the next; minimum 1, where 1 means back-to-back.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- mse_data  input  NUM_RES x DATA_W  MSE results; element 0 is sent first
- mse_valid  input  1  single-cycle pulse: mse_data is valid this cycle
- com_txvalid  output  1  single-cycle byte strobe to the UART transmitter
- com_txdata  output  8  byte to transmit; valid when com_txvalid=1
- busy  output  1  frame in progress
- overrun  output  1  sticky: a mse_valid pulse was dropped
- frame_cnt  output  8  number of frames completed, wraps

Behaviour:
- Reset: clk is the only clock; rstn is asynchronous, active-low. While rstn=0, all outputs are 0 and FSM=IDLE; gap counter, byte index, checksum and shadow registers are cleared.
- Reset mid-frame: the frame is abandoned immediately; no further bytes are emitted after rstn is released.
- Acceptance: mse_valid is accepted only when busy=0 (registered). On accept, all NUM_RES words are captured into shadow registers and busy=1 on the next cycle.
- Drop: mse_valid while busy=1 sets overrun=1. The data is dropped and the current frame is unaffected. overrun is cleared only by reset.
- FSM states:
  - IDLE -> HDR on accept.
  - HDR emits HEADER, then -> DATA.
  - DATA emits NUM_RES*DATA_W/8 bytes: word 0 first, MSB byte first within each word. Then -> CSUM.
  - CSUM emits the checksum, then -> IDLE. busy=0 and frame_cnt+1 on the cycle after the CSUM gap expires.
- Checksum: XOR of all payload bytes. HEADER is excluded.
- Pacing:
  - Each state asserts com_txvalid for exactly one cycle on entry, with com_txdata stable that cycle.
  - A gap counter then runs for GAP_CYCLES cycles before the next strobe. Strobe spacing is exactly GAP_CYCLES.
  - com_txdata holds its last value between strobes.
- Latency: if mse_valid is at cycle t, the header strobe is at t+1 and byte k (header is k=0) is at t+1+k*GAP_CYCLES.
- Frame length: 2+NUM_RES*DATA_W/8 bytes, which is 18 at the defaults. Frame duration is length*GAP_CYCLES cycles.
- Simultaneous events: mse_valid on the final gap cycle of CSUM (busy still 1) is an overrun, not an accept. mse_valid on the first cycle with busy=0 is accepted.
- frame_cnt wraps 255 -> 0. An abandoned frame (reset) is not counted.

Optional Feature:
- Macro: MSE_FRAME_SEQ_EN.
- Defined:
  - An extra SEQ state between HDR and DATA emits an 8-bit sequence byte equal to frame_cnt at the time of accept.
  - The sequence byte is included in the checksum.
  - Frame length is 3+NUM_RES*DATA_W/8 bytes (19 at the defaults).
- Undefined: no SEQ state and no sequence byte; frame format as in Behaviour.

Test Plan:
- GAP_CYCLES=4; mse_data[0]=64'h0102030405060708, mse_data[1]=0; pulse mse_valid at t -> strobes at t+1, t+5, ...; bytes A5,01,02,03,04,05,06,07,08, eight 00, 08. Then busy=0, frame_cnt=1.
- GAP_CYCLES=1; mse_data[0]=mse_data[1]=64'hFFFFFFFFFFFFFFFF -> 18 consecutive strobes: A5, sixteen FF, checksum 00.
- Second mse_valid during the 4th byte of a frame -> overrun=1 and stays 1; frame bytes unchanged from the first capture; frame_cnt increments by exactly 1.
- rstn low during the 6th byte, released 3 cycles later, no mse_valid -> com_txvalid stays 0, busy=0, frame_cnt=0, overrun=0.
- 256 back-to-back frames (each mse_valid on the first cycle with busy=0) -> no overrun; frame_cnt reads 0 after the 256th frame.
- MSE_FRAME_SEQ_EN defined, two frames with the first-scenario data -> frame 1 bytes are A5,00,payload,08; frame 2 bytes are A5,01,payload,09.
